// File: rtl/snd_latch_pkg.sv
// ---------------------------------------------------------------------------
// snd_latch_pkg
// Shared definitions for the M68K <-> Z80 sound latch bridge.
//   - NMI FSM state encoding. The state set depends on the build:
//       SOUND_LATCH_NMI_ACK_EN undefined : IDLE / PULSE (timed NMI pulse)
//       SOUND_LATCH_NMI_ACK_EN defined   : IDLE / HELD  (NMI held until Z80 read)
//   - Bus addresses of the mailbox registers. The bridge itself is driven by
//     pre-decoded chip selects; these are for the surrounding decode logic
//     and for testbenches.
// ---------------------------------------------------------------------------
package snd_latch_pkg;

  localparam logic [23:0] M68K_SND_LATCH_ADDR = 24'h080000;  // M68K command write
  localparam logic [23:0] M68K_SND_REPLY_ADDR = 24'h0f8000;  // M68K reply read
  localparam logic [15:0] Z80_SND_LATCH_ADDR  = 16'hf800;    // Z80 command read / reply write

`ifdef SOUND_LATCH_NMI_ACK_EN
  typedef enum logic {
    NMI_IDLE = 1'b0,
    NMI_HELD = 1'b1
  } nmi_state_e;
`else
  typedef enum logic {
    NMI_IDLE  = 1'b0,
    NMI_PULSE = 1'b1
  } nmi_state_e;
`endif

endpackage : snd_latch_pkg

// File: rtl/rise_edge_strobe.sv
// ---------------------------------------------------------------------------
// rise_edge_strobe
// Turns a level-style select, held for a whole bus cycle, into a one-cycle
// event on its rising edge. The previous value is registered; the event is
// the current level AND NOT the previous level, so it is valid in the same
// cycle the level first goes high.
//
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous, active-high reset (previous value -> 0)
//   level  in  1  level-style strobe
//   rise   out 1  single-cycle rising-edge event
// ---------------------------------------------------------------------------
module rise_edge_strobe (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule : rise_edge_strobe

// File: rtl/sound_latch_bridge.sv
// ---------------------------------------------------------------------------
// sound_latch_bridge
// Bidirectional 8-bit mailbox between the M68K main CPU and the Z80 sound
// CPU.
//   main -> sound : M68K writes a command byte, Z80 gets an NMI and reads it.
//   sound -> main : Z80 writes a reply byte, M68K reads it back.
// Each chip select may be held for many cycles; only its rising edge acts.
//
// Build option:
//   SOUND_LATCH_NMI_ACK_EN  defined   -> NMI held low until the Z80 reads
//                                        the command.
//                           undefined -> NMI is a NMI_PULSE_CYCLES-long
//                                        pulse, retriggered by each write.
//
// Parameters:
//   NMI_PULSE_CYCLES  clk cycles of NMI low per command write (pulse mode)
//   CNT_W             pulse counter width, 2**CNT_W > NMI_PULSE_CYCLES
//
// Ports:
//   clk                in   1  system clock
//   reset              in   1  synchronous, active-high reset
//   m68k_latch_cs      in   1  M68K command write select (write & !AS qualified)
//   z80_latch_read_cs  in   1  M68K reply read select
//   m68k_dout          in  16  M68K write data, command byte in [15:8]
//   m68k_latch2_dout   out  8  reply byte to the M68K read mux
//   z80_latch_cs       in   1  Z80 MREQ select for 0xf800
//   z80_rd_n           in   1  Z80 RD_n
//   z80_wr_n           in   1  Z80 WR_n
//   z80_dout           in   8  Z80 write data
//   z80_latch_dout     out  8  command byte to the Z80 read mux
//   z80_nmi_n          out  1  Z80 NMI, active low, registered
//   cmd_pending        out  1  command written, not yet read by the Z80
//   reply_pending      out  1  reply written, not yet read by the M68K
//
// NMI FSM states:
//   state      | meaning
//   NMI_IDLE   | z80_nmi_n high, waiting for a command write
//   NMI_PULSE  | z80_nmi_n low, counter running down to 0 (pulse mode)
//   NMI_HELD   | z80_nmi_n low until the Z80 reads the command (ack mode)
// ---------------------------------------------------------------------------
module sound_latch_bridge
  import snd_latch_pkg::*;
#(
  parameter int NMI_PULSE_CYCLES = 64,
  parameter int CNT_W            = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68k_latch_cs,
  input  logic        z80_latch_read_cs,
  input  logic [15:0] m68k_dout,
  output logic [7:0]  m68k_latch2_dout,
  input  logic        z80_latch_cs,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic [7:0]  z80_dout,
  output logic [7:0]  z80_latch_dout,
  output logic        z80_nmi_n,
  output logic        cmd_pending,
  output logic        reply_pending
);

  // Command travels on the even byte lane only.
  logic unused_m68k_low_byte;
  assign unused_m68k_low_byte = ^m68k_dout[7:0];

  // -------------------------------------------------------------------------
  // Bus-cycle edge detection
  // -------------------------------------------------------------------------
  logic z_rd_level;
  logic z_wr_level;
  logic m_wr_rise;
  logic m_rd_rise;
  logic z_rd_rise;
  logic z_wr_rise;

  assign z_rd_level = z80_latch_cs & ~z80_rd_n;
  assign z_wr_level = z80_latch_cs & ~z80_wr_n;

  rise_edge_strobe u_m_wr_edge (
    .clk   (clk),
    .reset (reset),
    .level (m68k_latch_cs),
    .rise  (m_wr_rise)
  );

  rise_edge_strobe u_m_rd_edge (
    .clk   (clk),
    .reset (reset),
    .level (z80_latch_read_cs),
    .rise  (m_rd_rise)
  );

  rise_edge_strobe u_z_rd_edge (
    .clk   (clk),
    .reset (reset),
    .level (z_rd_level),
    .rise  (z_rd_rise)
  );

  rise_edge_strobe u_z_wr_edge (
    .clk   (clk),
    .reset (reset),
    .level (z_wr_level),
    .rise  (z_wr_rise)
  );

  // -------------------------------------------------------------------------
  // Command latch (M68K -> Z80). A write on the same edge as a read wins,
  // so a command can never be silently lost behind a stale acknowledge.
  // -------------------------------------------------------------------------
  logic [7:0] cmd_latch;
  logic       cmd_pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_latch     <= 8'h00;
      cmd_pending_q <= 1'b0;
    end else if (m_wr_rise) begin
      cmd_latch     <= m68k_dout[15:8];
      cmd_pending_q <= 1'b1;
    end else if (z_rd_rise) begin
      cmd_pending_q <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Reply latch (Z80 -> M68K), same write-wins rule.
  // -------------------------------------------------------------------------
  logic [7:0] reply_latch;
  logic       reply_pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      reply_latch     <= 8'h00;
      reply_pending_q <= 1'b0;
    end else if (z_wr_rise) begin
      reply_latch     <= z80_dout;
      reply_pending_q <= 1'b1;
    end else if (m_rd_rise) begin
      reply_pending_q <= 1'b0;
    end
  end

  assign z80_latch_dout   = cmd_latch;
  assign m68k_latch2_dout = reply_latch;
  assign cmd_pending      = cmd_pending_q;
  assign reply_pending    = reply_pending_q;

  // -------------------------------------------------------------------------
  // NMI FSM. z80_nmi_n is a flop so the Z80 never sees a decode glitch.
  // -------------------------------------------------------------------------
  nmi_state_e nmi_state;
  logic       nmi_n_q;

`ifdef SOUND_LATCH_NMI_ACK_EN

  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_state <= NMI_IDLE;
      nmi_n_q   <= 1'b1;
    end else begin
      case (nmi_state)
        NMI_IDLE: begin
          if (m_wr_rise) begin
            nmi_state <= NMI_HELD;
            nmi_n_q   <= 1'b0;
          end
        end
        NMI_HELD: begin
          // A fresh command on the acknowledging edge keeps the NMI asserted.
          if (z_rd_rise && !m_wr_rise) begin
            nmi_state <= NMI_IDLE;
            nmi_n_q   <= 1'b1;
          end
        end
        default: begin
          nmi_state <= NMI_IDLE;
          nmi_n_q   <= 1'b1;
        end
      endcase
    end
  end

`else

  localparam logic [CNT_W-1:0] NMI_LOAD = CNT_W'(NMI_PULSE_CYCLES - 1);

  logic [CNT_W-1:0] nmi_cnt;

  // Counter holds the number of low cycles still to come after the current
  // one; it stops at 0, so it never wraps and rests at 0 in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_state <= NMI_IDLE;
      nmi_n_q   <= 1'b1;
      nmi_cnt   <= '0;
    end else begin
      case (nmi_state)
        NMI_IDLE: begin
          if (m_wr_rise) begin
            nmi_state <= NMI_PULSE;
            nmi_n_q   <= 1'b0;
            nmi_cnt   <= NMI_LOAD;
          end
        end
        NMI_PULSE: begin
          if (m_wr_rise) begin
            nmi_cnt <= NMI_LOAD;
          end else if (nmi_cnt == '0) begin
            nmi_state <= NMI_IDLE;
            nmi_n_q   <= 1'b1;
          end else begin
            nmi_cnt <= nmi_cnt - CNT_W'(1);
          end
        end
        default: begin
          nmi_state <= NMI_IDLE;
          nmi_n_q   <= 1'b1;
          nmi_cnt   <= '0;
        end
      endcase
    end
  end

`endif

  assign z80_nmi_n = nmi_n_q;

endmodule : sound_latch_bridge

// File: doc/sound_latch_bridge.md
Name: sound_latch_bridge

Overview:
Bidirectional 8-bit mailbox between the M68K main CPU and the Z80 sound CPU, driven by the chip-select decode.
- Main-to-sound path: M68K writes the sound command at 0x080000; this raises the Z80 NMI. The Z80 reads the command at 0xf800.
- Sound-to-main path: the Z80 writes a reply byte at 0xf800. M68K reads it back at 0x0f8000.
- Converts level-style chip selects, held for a whole bus cycle, into single-cycle capture and acknowledge events.

Parameters:
- NMI_PULSE_CYCLES, 64: clk cycles that z80_nmi_n stays low per command write (pulse mode only).
- CNT_W, 8: width of the NMI pulse counter; must satisfy 2^CNT_W > NMI_PULSE_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m68k_latch_cs  in  1  M68K write select for the sound command, already qualified with write and !AS
- z80_latch_read_cs  in  1  M68K read select for the reply byte
- m68k_dout  in  16  M68K write data; the command byte is bits [15:8] (even-byte access)
- m68k_latch2_dout  out  8  reply byte presented to the M68K read mux
- z80_latch_cs  in  1  Z80 MREQ select for address 0xf800
- z80_rd_n  in  1  Z80 RD_n
- z80_wr_n  in  1  Z80 WR_n
- z80_dout  in  8  Z80 write data
- z80_latch_dout  out  8  command byte presented to the Z80 read mux
- z80_nmi_n  out  1  Z80 NMI, active low
- cmd_pending  out  1  command written but not yet read by the Z80
- reply_pending  out  1  reply written but not yet read by the M68K

Behaviour:
- Reset values: both latches 0x00, cmd_pending 0, reply_pending 0, z80_nmi_n 1, counter 0.
- Events are the rising edges of four registered strobes:
  - m_wr = m68k_latch_cs
  - m_rd = z80_latch_read_cs
  - z_rd = z80_latch_cs & !z80_rd_n
  - z_wr = z80_latch_cs & !z80_wr_n
- Each event fires exactly once per bus cycle, however long the select is held. The previous-value registers reset to 0.
- m_wr edge:
  - command latch <= m68k_dout[15:8], sampled in the edge cycle.
  - cmd_pending <= 1.
  - NMI trigger.
  - New data appears on z80_latch_dout the next cycle.
- z_rd edge: cmd_pending <= 0 and NMI acknowledge (ack-mode only). z80_latch_dout is a direct register output, valid at all times.
- z_wr edge: reply latch <= z80_dout; reply_pending <= 1.
- m_rd edge: reply_pending <= 0.
- Simultaneous m_wr and z_rd in the same cycle: the write wins. Latch is updated, cmd_pending stays 1, and the NMI is (re)triggered.
- Simultaneous z_wr and m_rd: the write wins; reply_pending stays 1.
- Overwrite without a read: the latch takes the new value, pending stays 1, no error flag.
- NMI FSM, pulse mode (states IDLE, PULSE):
  - IDLE: z80_nmi_n=1. A trigger loads the counter with NMI_PULSE_CYCLES-1 and moves to PULSE.
  - PULSE: z80_nmi_n=0; the counter decrements and the FSM returns to IDLE when it reaches 0.
  - A trigger during PULSE reloads the counter (retrigger extends the pulse).
  - z80_nmi_n goes low on the cycle after the m_wr edge and is registered glitch-free.
- Reset asserted mid-pulse or mid-transfer: all state returns to reset values on the next clk edge.
- Widths: the counter never underflows; a counter at 0 in IDLE stays 0.

Optional Feature:
- Macro: SOUND_LATCH_NMI_ACK_EN.
- Defined: the NMI FSM has states IDLE and HELD.
  - A trigger moves to HELD; z80_nmi_n=0.
  - A z_rd edge returns to IDLE, unless an m_wr edge occurs in the same cycle, in which case the FSM stays in HELD.
  - The counter and NMI_PULSE_CYCLES are unused.
- Not defined: pulse-mode behaviour as above.

Decomposition:
- Shared package snd_latch_pkg:
  - NMI state enum.
  - Localparams M68K_SND_LATCH_ADDR=24'h080000, M68K_SND_REPLY_ADDR=24'h0f8000 and Z80_SND_LATCH_ADDR=16'hf800, for documentation and testbench use.
- One natural sub-module, rise_edge_strobe: a 1-bit registered previous value plus AND-NOT, instantiated four times.

Test Plan:
- Reset, then hold m68k_latch_cs high for 6 cycles with m68k_dout=16'hA5xx → z80_latch_dout=8'hA5 and cmd_pending=1 from the cycle after the edge; exactly one capture; z80_nmi_n low for exactly 64 cycles (pulse mode).
- Z80 read (z80_latch_cs=1, z80_rd_n=0 for 3 cycles) after a command → cmd_pending=0 the next cycle, z80_latch_dout still 8'hA5; with SOUND_LATCH_NMI_ACK_EN, z80_nmi_n returns to 1 on the same cycle.
- Z80 write 8'h3C at 0xf800 → m68k_latch2_dout=8'h3C, reply_pending=1; then z80_latch_read_cs held 4 cycles → reply_pending=0, data unchanged.
- m_wr edge with data 8'h11 coinciding with a z_rd edge → latch=8'h11, cmd_pending=1, NMI retriggered (pulse count restarts, or stays HELD in ack mode).
- Second command 8'h22 written 10 cycles into a pulse → latch=8'h22, z80_nmi_n stays low until 64 cycles after the second write.
- Reset asserted at cycle 20 of an NMI pulse with both pending flags set → next cycle z80_nmi_n=1, both flags 0, both latches 0x00.
